key_schedule_ctrl: RTL and testbench
====================================

Name: key_schedule_ctrl

Overview:
- Sequences the team's single-round key-expansion unit (key in, RCj in, hold/clear in, subkey out) through all 10 AES-128 rounds.
- Generates the RCj sequence and stores the 11 round keys in an internal table.
- Serves the table to the cipher core via a registered read port.
- Uses a start/done handshake with an abort input.

Parameters:
- ROUND_LAT, 2, number of cycles the round unit needs from stable inputs (hold low) to a valid subkey. Legal range 1..7.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset: 0 = reset.
- start_i  in  1  request a full expansion of key_i; sampled only in IDLE.
- abort_i  in  1  cancel an expansion in progress.
- key_i  in  [0:127]  cipher key; byte 0 = key_i[0:7]; sampled on the start edge.
- busy_o  out  1  high in ISSUE/WAIT.
- done_o  out  1  one-cycle pulse when all 11 keys are stored.
- valid_o  out  1  level: the table holds a complete, consistent schedule.
- rk_key_o  out  [0:127]  previous round key, driven to the round unit.
- rk_rcon_o  out  [0:7]  RCj for the current round.
- rk_hold_o  out  1  round unit clear/hold (unit exp_en); high except during ISSUE/WAIT.
- rk_subkey_i  in  [0:127]  round unit result.
- rd_idx_i  in  4  round-key index 0..10.
- rd_key_o  out  [0:127]  round key, 1-cycle registered read.

Behaviour:
- Reset (reset=0, async): state=IDLE, round=0, cnt=0, all 11 table entries=0, busy_o=0, done_o=0, valid_o=0, rk_key_o=0, rk_rcon_o=0, rk_hold_o=1, rd_key_o=0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On start_i=1 and abort_i=0: table[0]<=key_i, rk_key_o<=key_i, round<=1, rk_rcon_o<=8'h01, valid_o<=0, go ISSUE.
  - start_i=1 together with abort_i=1 in IDLE: start is ignored.
- ISSUE (1 cycle): rk_hold_o=0, busy_o=1, cnt<=ROUND_LAT-1, go WAIT.
- WAIT:
  - rk_hold_o=0, and rk_key_o/rk_rcon_o are held stable.
  - cnt decrements each cycle.
  - On the edge ending the cycle with cnt==0: table[round]<=rk_subkey_i and rk_key_o<=rk_subkey_i.
  - If round==10, go DONE. Else round<=round+1, rk_rcon_o<=next RCj, go ISSUE.
- RCj sequence for rounds 1..10: 01 02 04 08 10 20 40 80 1B 36. Next value = xtime(prev): shift left 1, XOR 1B if bit 7 was set.
- DONE (1 cycle): done_o=1, valid_o<=1, rk_hold_o=1, busy_o=0, go IDLE.
- Latency:
  - ROUND_LAT+1 cycles per round.
  - done_o is high in cycle 10*(ROUND_LAT+1) after the start edge (30 for the default).
- start_i while busy is ignored (no queueing).
- abort_i=1 in ISSUE/WAIT:
  - Next state IDLE, rk_hold_o=1, valid_o=0, no done_o.
  - Already-written table entries keep their values.
- Read port:
  - rd_key_o<=table[rd_idx_i] every cycle.
  - rd_idx_i>10 gives 0.
  - Reads are legal at any time. During busy they return whatever is stored; consumers must qualify with valid_o.
- A table write and a read of the same index in the same cycle return the old value (read-before-write).
- Reset mid-expansion aborts immediately and clears everything as above.

Optional Feature:
- Macro: KEY_SCHEDULE_REUSE_EN.
- Defined:
  - A 128-bit register last_key holds the key of the last completed expansion.
  - A start with valid_o=1 and key_i==last_key skips ISSUE/WAIT: IDLE->DONE directly, so done_o pulses 1 cycle after the start edge and the table is untouched.
  - last_key is cleared on reset.
  - Abort clears valid_o, which defeats reuse.
- Not defined: every start runs the full 10 rounds, and no last_key register exists.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, round unit with ROUND_LAT=2 -> done_o pulses 30 cycles after start; valid_o=1; rd_idx=1 gives a0fafe1788542cb123a339392a6c7605; rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; rd_idx=0 gives the key.
- Same run, monitor rk_rcon_o at each ISSUE -> exactly 01,02,04,08,10,20,40,80,1B,36; rk_hold_o=0 only in ISSUE/WAIT.
- Start, abort_i=1 in round 4 WAIT -> IDLE next cycle, no done_o, valid_o=0, rk_hold_o=1; a new start then completes normally.
- start_i pulsed again at cycle 10 of a run -> ignored; done_o pulses once at cycle 30 with correct keys. rd_idx=15 -> rd_key_o=0.
- reset driven low at cycle 17 (async, mid-clock) -> all outputs immediately at reset values, table reads 0 after release.
- With KEY_SCHEDULE_REUSE_EN: repeat the same key after completion -> done_o 1 cycle after start, no ISSUE. Different key -> full 30-cycle run. Without the macro: the repeat takes 30 cycles.

Source files
------------

// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - AES-128 key schedule sequencer with round-key table and registered read port
// Optional feature macro: KEY_SCHEDULE_REUSE_EN (skip re-expansion when the same key is requested again)
`timescale 1ns/1ps
module key_schedule_ctrl #(
  parameter int ROUND_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [0:127] key_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         valid_o,
  output logic [0:127] rk_key_o,
  output logic [0:7]   rk_rcon_o,
  output logic         rk_hold_o,
  input  logic [0:127] rk_subkey_i,
  input  logic [3:0]   rd_idx_i,
  output logic [0:127] rd_key_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int         NUM_KEYS   = 11;
  localparam logic [3:0] LAST_ROUND = 4'd10;
  localparam logic [2:0] CNT_LOAD   = 3'(ROUND_LAT - 1);

  state_t       state;
  state_t       state_nxt;
  logic [3:0]   round;
  logic [2:0]   cnt;
  logic [0:127] rk_table [0:NUM_KEYS-1];
  logic         start_ok;
  logic         reuse_hit;
  logic         capture;

  // GF(2^8) doubling used to step the round constant
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign start_ok = start_i & ~abort_i;
  assign capture  = (state == WAIT) && !abort_i && (cnt == 3'd0);

`ifdef KEY_SCHEDULE_REUSE_EN
  logic [0:127] last_key;

  // Remember which key the completed table was expanded from
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_key <= '0;
    end else if (state == DONE) begin
      last_key <= rk_table[0];
    end
  end

  assign reuse_hit = valid_o && (key_i == last_key);
`else
  assign reuse_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort wins over any progress in ISSUE/WAIT
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = reuse_hit ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = abort_i ? IDLE : WAIT;
      end
      WAIT: begin
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (cnt == 3'd0) begin
          state_nxt = (round == LAST_ROUND) ? DONE : ISSUE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State-decoded outputs; the round unit is only released while a round is in flight
  always_comb begin
    busy_o    = (state == ISSUE) || (state == WAIT);
    rk_hold_o = !((state == ISSUE) || (state == WAIT));
    done_o    = (state == DONE);
  end

  // Round sequencing, round-unit operand registers and the validity flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round     <= 4'd0;
      cnt       <= 3'd0;
      valid_o   <= 1'b0;
      rk_key_o  <= '0;
      rk_rcon_o <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok && !reuse_hit) begin
            rk_key_o  <= key_i;
            round     <= 4'd1;
            rk_rcon_o <= 8'h01;
            valid_o   <= 1'b0;
          end
        end
        ISSUE: begin
          if (abort_i) begin
            valid_o <= 1'b0;
          end else begin
            cnt <= CNT_LOAD;
          end
        end
        WAIT: begin
          if (abort_i) begin
            valid_o <= 1'b0;
          end else if (cnt == 3'd0) begin
            rk_key_o <= rk_subkey_i;
            if (round != LAST_ROUND) begin
              round     <= round + 4'd1;
              rk_rcon_o <= xtime(rk_rcon_o);
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          valid_o <= 1'b1;
        end
        default: begin
          valid_o <= 1'b0;
        end
      endcase
    end
  end

  // Round-key table: key loads entry 0, each finished round fills its own entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        rk_table[i] <= '0;
      end
    end else begin
      if ((state == IDLE) && start_ok && !reuse_hit) begin
        rk_table[0] <= key_i;
      end
      if (capture) begin
        for (int i = 1; i < NUM_KEYS; i++) begin
          if (round == 4'(i)) begin
            rk_table[i] <= rk_subkey_i;
          end
        end
      end
    end
  end

  // Registered read port; sees the pre-write value on a same-cycle write, out-of-range reads 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_key_o <= '0;
    end else begin
      rd_key_o <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (rd_idx_i == 4'(i)) begin
          rd_key_o <= rk_table[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb/tb_key_schedule_ctrl.sv - directed self-checking bench for key_schedule_ctrl
`timescale 1ns/1ps
module tb_key_schedule_ctrl;

  localparam int LAT = 2;
  localparam logic [0:127] KEY_A   = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [0:127] KEY_B   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [0:127] R1_A    = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [0:127] R3_A    = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
  localparam logic [0:127] R10_A   = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [0:127] GARBAGE = 128'hdeadbeef_0badf00d_deadbeef_0badf00d;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic [0:127] key_i = '0;
  logic         busy_o;
  logic         done_o;
  logic         valid_o;
  logic [0:127] rk_key_o;
  logic [0:7]   rk_rcon_o;
  logic         rk_hold_o;
  logic [0:127] rk_subkey;
  logic [3:0]   rd_idx = 4'd0;
  logic [0:127] rd_key_o;

  int tests = 0;
  int fails = 0;

  logic [0:2047] sbox_bits = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic [7:0]   rc_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [0:127] exp_a [11];
  logic [0:127] exp_b [11];

  always #5 clk = ~clk;

  key_schedule_ctrl #(.ROUND_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .key_i      (key_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .valid_o    (valid_o),
    .rk_key_o   (rk_key_o),
    .rk_rcon_o  (rk_rcon_o),
    .rk_hold_o  (rk_hold_o),
    .rk_subkey_i(rk_subkey),
    .rd_idx_i   (rd_idx),
    .rd_key_o   (rd_key_o)
  );

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    int i;
    i = int'(b);
    return sbox_bits[8*i +: 8];
  endfunction

  function automatic logic [7:0] tb_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:127] expand(input logic [0:127] k, input logic [7:0] rc);
    logic [0:31] w0, w1, w2, w3, t;
    w0 = k[0:31];
    w1 = k[32:63];
    w2 = k[64:95];
    w3 = k[96:127];
    t  = {sub_byte(w3[8:15]), sub_byte(w3[16:23]), sub_byte(w3[24:31]), sub_byte(w3[0:7])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Round-unit model: result is only meaningful after LAT stable, released cycles
  int           age = 0;
  logic [0:127] p_key = '0;
  logic [0:7]   p_rcon = '0;
  always @(posedge clk) begin
    if (rk_hold_o) age <= 0;
    else if (rk_key_o !== p_key || rk_rcon_o !== p_rcon) age <= 1;
    else age <= age + 1;
    p_key  <= rk_key_o;
    p_rcon <= rk_rcon_o;
  end
  assign rk_subkey = (age >= LAT) ? expand(rk_key_o, rk_rcon_o) : GARBAGE;

  // Interface monitor: round constants at each round start, hold/busy agreement, done pulses
  logic [7:0]   rcon_log [$];
  int           hold_low = 0;
  int           done_cnt = 0;
  int           hb_err = 0;
  logic         prev_hold = 1'b1;
  logic [0:127] prev_key = '0;
  always @(negedge clk) begin
    if (!rk_hold_o && (prev_hold || rk_key_o !== prev_key)) rcon_log.push_back(rk_rcon_o);
    if (!rk_hold_o) hold_low++;
    if (rk_hold_o === busy_o) hb_err++;
    if (done_o === 1'b1) done_cnt++;
    prev_hold = rk_hold_o;
    prev_key  = rk_key_o;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [0:127] k);
    start_i = 1'b1;
    key_i   = k;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic run_wait(output int c);
    c = 0;
    while (done_o !== 1'b1 && c < 100) begin
      tick(1);
      c++;
    end
  endtask

  task automatic read_check(input string tag, input int idx, input logic [0:127] exp);
    rd_idx = 4'(idx);
    tick(1);
    check(tag, rd_key_o, exp);
  endtask

  initial begin
    int cyc;
    int done_at;
    int base_rc;
    int base_hold;
    int base_done;
    logic [7:0] rc;

    exp_a[0] = KEY_A;
    exp_b[0] = KEY_B;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      exp_a[r] = expand(exp_a[r-1], rc);
      exp_b[r] = expand(exp_b[r-1], rc);
      rc = tb_xtime(rc);
    end

    // Reset values
    #2 reset = 1'b0;
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_rk_key", rk_key_o, 0);
    check("rst_rcon", rk_rcon_o, 0);
    check("rst_hold", rk_hold_o, 1);
    check("rst_rd_key", rd_key_o, 0);
    tick(2);
    reset = 1'b1;
    tick(1);

    // Full FIPS-197 expansion
    base_rc = rcon_log.size();
    base_hold = hold_low;
    base_done = done_cnt;
    do_start(KEY_A);
    check("run1_busy", busy_o, 1);
    check("run1_hold", rk_hold_o, 0);
    check("run1_rk_key", rk_key_o, KEY_A);
    check("run1_rcon0", rk_rcon_o, 8'h01);
    run_wait(cyc);
    check("run1_latency", cyc, 30);
    check("run1_valid_in_done", valid_o, 0);
    tick(1);
    check("run1_valid", valid_o, 1);
    check("run1_done_after", done_o, 0);
    check("run1_busy_after", busy_o, 0);
    check("run1_done_pulses", done_cnt - base_done, 1);
    check("run1_hold_low_cycles", hold_low - base_hold, 30);
    check("run1_rcon_count", rcon_log.size() - base_rc, 10);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("run1_rcon_%0d", k), (base_rc + k < rcon_log.size()) ? rcon_log[base_rc + k] : 8'hxx, rc_exp[k]);
    end
    for (int i = 0; i <= 10; i++) read_check($sformatf("run1_rd_%0d", i), i, exp_a[i]);
    read_check("run1_rd1_fips", 1, R1_A);
    read_check("run1_rd10_fips", 10, R10_A);
    read_check("run1_rd0_key", 0, KEY_A);
    read_check("run1_rd15_zero", 15, 128'h0);

    // Second key, stray start at cycle 10, read-before-write on entry 1
    base_done = done_cnt;
    done_at = 0;
    rd_idx = 4'd1;
    do_start(KEY_B);
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) begin
        start_i = 1'b1;
        key_i   = KEY_A;
      end
      tick(1);
      start_i = 1'b0;
      if (c == 3) check("run2_rbw_old", rd_key_o, exp_a[1]);
      if (c == 4) check("run2_rbw_new", rd_key_o, exp_b[1]);
      if (c == 10) check("run2_busy_after_stray_start", busy_o, 1);
      if (done_o === 1'b1 && done_at == 0) done_at = c;
    end
    check("run2_done_at", done_at, 30);
    check("run2_done_pulses", done_cnt - base_done, 1);
    read_check("run2_rd0", 0, KEY_B);
    read_check("run2_rd5", 5, exp_b[5]);
    read_check("run2_rd10", 10, exp_b[10]);
    read_check("run2_rd15_zero", 15, 128'h0);

    // Abort in round 4 WAIT, then restart
    base_done = done_cnt;
    do_start(KEY_A);
    tick(10);
    check("abort_busy_before", busy_o, 1);
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_hold", rk_hold_o, 1);
    check("abort_valid", valid_o, 0);
    check("abort_done", done_o, 0);
    tick(3);
    check("abort_no_done", done_cnt - base_done, 0);
    check("abort_stays_idle", busy_o, 0);
    read_check("abort_rd3", 3, R3_A);
    read_check("abort_rd4_old", 4, exp_b[4]);
    read_check("abort_rd0", 0, KEY_A);
    do_start(KEY_A);
    run_wait(cyc);
    check("restart_latency", cyc, 30);
    tick(1);
    check("restart_valid", valid_o, 1);
    read_check("restart_rd10", 10, R10_A);

    // Same key again
    base_done = done_cnt;
    base_hold = hold_low;
    do_start(KEY_A);
`ifdef KEY_SCHEDULE_REUSE_EN
    check("reuse_done_immediate", done_o, 1);
    check("reuse_busy", busy_o, 0);
    tick(1);
    check("reuse_valid", valid_o, 1);
    check("reuse_no_issue", hold_low - base_hold, 0);
    check("reuse_done_pulses", done_cnt - base_done, 1);
`else
    check("repeat_no_early_done", done_o, 0);
    run_wait(cyc);
    check("repeat_latency", cyc, 30);
    tick(1);
    check("repeat_valid", valid_o, 1);
`endif
    read_check("repeat_rd10", 10, R10_A);

    // Asynchronous reset in the middle of a run
    do_start(KEY_B);
    tick(16);
    check("midrst_busy_before", busy_o, 1);
    #3 reset = 1'b0;
    #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_valid", valid_o, 0);
    check("midrst_rk_key", rk_key_o, 0);
    check("midrst_rcon", rk_rcon_o, 0);
    check("midrst_hold", rk_hold_o, 1);
    check("midrst_rd_key", rd_key_o, 0);
    tick(1);
    reset = 1'b1;
    read_check("midrst_rd0", 0, 128'h0);
    read_check("midrst_rd1", 1, 128'h0);
    read_check("midrst_rd10", 10, 128'h0);
    check("midrst_idle", busy_o, 0);

    check("hold_vs_busy", hb_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
